// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset CPU: ALU ops, opcodes,
// R-type function codes, control FSM states and datapath mux selects.
package mc_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_PASS = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_REG    = 1'b1;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    REXEC, RWB, IEXEC, IWB, BRANCH, JUMP
  } state_t;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type function decoder: maps funct to an ALU operation and flags
// function codes the CPU does not implement.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] aluop_o,
  output logic       illegal_o
);

  always_comb begin
    aluop_o   = ALU_ADD;
    illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  aluop_o = ALU_ADD;
      FN_SUB:  aluop_o = ALU_SUB;
      FN_OR:   aluop_o = ALU_OR;
      FN_AND:  aluop_o = ALU_AND;
      FN_SLT:  aluop_o = ALU_SLT;
      FN_NOR:  aluop_o = ALU_NOR;
      FN_SRL:  aluop_o = ALU_SRL;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute for the MIPS subset
// and drives every datapath enable, mux select and ALU operation.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode_i,
  input  logic [5:0]         funct_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         pc_src_o,
  output logic               pc_en_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               reg_write_o,
  output logic               instr_done_o,
  output logic               illegal_o
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] w_aluop;
  logic [2:0] w_dec_aluop;
  logic       w_dec_illegal;
  logic       w_ready;

  assign w_ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;
  assign aluop_o = ALUOP_W'(w_aluop);

  mc_alu_dec u_alu_dec (
    .funct_i   (funct_i),
    .aluop_o   (w_dec_aluop),
    .illegal_o (w_dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RST;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_aluop      = ALU_ADD;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_REG;
    pc_src_o     = PC_ALU;
    pc_en_o      = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    case (r_state)
      S_RST: w_next = FETCH;
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        // PC and IR only load in the cycle memory returns the instruction
        if (w_ready) begin
          ir_write_o = 1'b1;
          pc_en_o    = 1'b1;
          w_next     = DECODE;
        end
      end
      DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        case (opcode_i)
          OP_LW, OP_SW:    w_next = MEMADR;
          OP_R:            w_next = REXEC;
          OP_ADDI, OP_ORI: w_next = IEXEC;
          OP_BEQ:          w_next = BRANCH;
          OP_J:            w_next = JUMP;
          default: begin
            illegal_o    = 1'b1;
            instr_done_o = 1'b1;
            w_next       = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_o = SRCA_REG;
        alu_src_b_o = SRCB_IMM;
        w_next      = (opcode_i == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (w_ready) w_next = MEMWB;
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
        w_next       = FETCH;
      end
      MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (w_ready) begin
          instr_done_o = 1'b1;
          w_next       = FETCH;
        end
      end
      REXEC: begin
        alu_src_a_o = SRCA_REG;
        if (w_dec_illegal) begin
          illegal_o    = 1'b1;
          instr_done_o = 1'b1;
          w_next       = FETCH;
        end else begin
          w_aluop = w_dec_aluop;
          w_next  = RWB;
        end
      end
      RWB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
        w_next       = FETCH;
      end
      IEXEC: begin
        alu_src_a_o = SRCA_REG;
        alu_src_b_o = SRCB_IMM;
        w_aluop     = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
        w_next      = IWB;
      end
      IWB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        w_next       = FETCH;
      end
      BRANCH: begin
        alu_src_a_o  = SRCA_REG;
        w_aluop      = ALU_SUB;
        pc_src_o     = PC_ALUOUT;
        pc_en_o      = zero_i;
        instr_done_o = 1'b1;
        w_next       = FETCH;
      end
      JUMP: begin
        pc_src_o     = PC_JUMP;
        pc_en_o      = 1'b1;
        instr_done_o = 1'b1;
        w_next       = FETCH;
      end
      default: w_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control vector and compares.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode_i = '0;
  logic [5:0] funct_i = '0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic [2:0] aluop_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] pc_src_o;
  logic       pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, instr_done_o, illegal_o;

  int tests = 0;
  int fails = 0;

  mc_ctrl #(.ALUOP_W(3), .MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .aluop_o(aluop_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o),
    .pc_en_o(pc_en_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // flag layout: {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, done, illegal}
  localparam logic [9:0] F_PE   = 10'b1000000000;
  localparam logic [9:0] F_IORD = 10'b0100000000;
  localparam logic [9:0] F_MR   = 10'b0010000000;
  localparam logic [9:0] F_MW   = 10'b0001000000;
  localparam logic [9:0] F_IRW  = 10'b0000100000;
  localparam logic [9:0] F_RD   = 10'b0000010000;
  localparam logic [9:0] F_M2R  = 10'b0000001000;
  localparam logic [9:0] F_RW   = 10'b0000000100;
  localparam logic [9:0] F_DONE = 10'b0000000010;
  localparam logic [9:0] F_ILL  = 10'b0000000001;

  typedef struct {
    logic        rdy;
    logic        zr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [17:0] exp;
    string       tag;
  } cyc_t;

  cyc_t q[$];

  function automatic logic [17:0] mk(input logic [2:0] a, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] ps,
                                     input logic [9:0] fl);
    return {a, sa, sb, ps, fl};
  endfunction

  function automatic logic [17:0] observed();
    return {aluop_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_en_o, iord_o,
            mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
            reg_write_o, instr_done_o, illegal_o};
  endfunction

  task automatic push(input logic rdy, input logic zr, input logic [5:0] op,
                      input logic [5:0] fn, input logic [17:0] e, input string tag);
    cyc_t c;
    c.rdy = rdy; c.zr = zr; c.op = op; c.fn = fn; c.exp = e; c.tag = tag;
    q.push_back(c);
  endtask

  // Instruction-level reference: the cycles an instruction occupies and what
  // the datapath must see in each, from the ISA timing rules.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn,
                     input int fw, input int mw, input logic z);
    logic [2:0] r_alu;
    bit         fn_ok;
    bit         op_ok;
    for (int i = 0; i < fw; i++)
      push(1'b0, 1'($urandom), op, fn, mk(3'd0, 0, 2'b01, 2'b00, F_MR), "fetch_wait");
    push(1'b1, 1'($urandom), op, fn, mk(3'd0, 0, 2'b01, 2'b00, F_MR | F_IRW | F_PE), "fetch");
    op_ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000100) ||
            (op == 6'b001000) || (op == 6'b001101) || (op == 6'b000010);
    push(1'($urandom), 1'($urandom), op, fn,
         mk(3'd0, 0, 2'b11, 2'b00, op_ok ? 10'd0 : (F_ILL | F_DONE)), "decode");
    if (!op_ok) return;
    case (op)
      6'b100011, 6'b101011: begin
        push(1'($urandom), 1'($urandom), op, fn, mk(3'd0, 1, 2'b10, 2'b00, 10'd0), "memadr");
        if (op == 6'b100011) begin
          for (int i = 0; i < mw; i++)
            push(1'b0, 1'($urandom), op, fn, mk(3'd0, 0, 2'b00, 2'b00, F_MR | F_IORD), "memrd_wait");
          push(1'b1, 1'($urandom), op, fn, mk(3'd0, 0, 2'b00, 2'b00, F_MR | F_IORD), "memrd");
          push(1'($urandom), 1'($urandom), op, fn, mk(3'd0, 0, 2'b00, 2'b00, F_RW | F_M2R | F_DONE), "memwb");
        end else begin
          for (int i = 0; i < mw; i++)
            push(1'b0, 1'($urandom), op, fn, mk(3'd0, 0, 2'b00, 2'b00, F_MW | F_IORD), "memwr_wait");
          push(1'b1, 1'($urandom), op, fn, mk(3'd0, 0, 2'b00, 2'b00, F_MW | F_IORD | F_DONE), "memwr");
        end
      end
      6'b000000: begin
        fn_ok = 1'b1;
        case (fn)
          6'b100000: r_alu = 3'd0;
          6'b100010: r_alu = 3'd1;
          6'b100101: r_alu = 3'd2;
          6'b100100: r_alu = 3'd3;
          6'b101010: r_alu = 3'd4;
          6'b100111: r_alu = 3'd5;
          6'b000010: r_alu = 3'd7;
          default: begin r_alu = 3'd0; fn_ok = 1'b0; end
        endcase
        if (!fn_ok) begin
          push(1'($urandom), 1'($urandom), op, fn, mk(3'd0, 1, 2'b00, 2'b00, F_ILL | F_DONE), "rexec_ill");
        end else begin
          push(1'($urandom), 1'($urandom), op, fn, mk(r_alu, 1, 2'b00, 2'b00, 10'd0), "rexec");
          push(1'($urandom), 1'($urandom), op, fn, mk(3'd0, 0, 2'b00, 2'b00, F_RW | F_RD | F_DONE), "rwb");
        end
      end
      6'b001000, 6'b001101: begin
        push(1'($urandom), 1'($urandom), op, fn,
             mk((op == 6'b001101) ? 3'd2 : 3'd0, 1, 2'b10, 2'b00, 10'd0), "iexec");
        push(1'($urandom), 1'($urandom), op, fn, mk(3'd0, 0, 2'b00, 2'b00, F_RW | F_DONE), "iwb");
      end
      6'b000100:
        push(1'($urandom), z, op, fn, mk(3'd1, 1, 2'b00, 2'b01, z ? (F_PE | F_DONE) : F_DONE), "branch");
      default:
        push(1'($urandom), 1'($urandom), op, fn, mk(3'd0, 0, 2'b00, 2'b10, F_PE | F_DONE), "jump");
    endcase
  endtask

  task automatic run_q(input string name, input int lim);
    cyc_t c;
    int   n = 0;
    while (q.size() > 0 && n < lim) begin
      c = q.pop_front();
      @(posedge clk); #1;
      opcode_i = c.op; funct_i = c.fn; mem_ready_i = c.rdy; zero_i = c.zr;
      @(negedge clk);
      tests++;
      if (observed() !== c.exp) begin
        fails++;
        $display("FAIL %s/%s cycle %0d: got %05h expected %05h", name, c.tag, n, observed(), c.exp);
      end
      n++;
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (observed() !== 18'd0) begin
      fails++;
      $display("FAIL %s: got %05h expected 00000", name, observed());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready_i = 1'b1; zero_i = 1'b1;
    check_zero("reset_held");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset_srst_cycle");
  endtask

  task automatic test_add();
    gen(6'b000000, 6'b100000, 0, 0, 1'b0);
    run_q("add", 100);
  endtask

  task automatic test_lw_wait();
    gen(6'b100011, 6'h15, 0, 3, 1'b0);
    tests++;
    if (q.size() != 8) begin
      fails++;
      $display("FAIL lw_len: got %0d expected 8", q.size());
    end
    run_q("lw_wait", 100);
  endtask

  task automatic test_beq();
    gen(6'b000100, 6'h2a, 0, 0, 1'b1);
    run_q("beq_taken", 100);
    gen(6'b000100, 6'h2a, 0, 0, 1'b0);
    run_q("beq_not_taken", 100);
  endtask

  task automatic test_illegal_op();
    gen(6'b111111, 6'h20, 0, 0, 1'b0);
    run_q("illegal_op", 100);
    gen(6'b001000, 6'h07, 1, 0, 1'b0);
    run_q("after_illegal", 100);
  endtask

  task automatic test_srl_bad_funct();
    gen(6'b000000, 6'b000010, 0, 0, 1'b0);
    run_q("srl", 100);
    gen(6'b000000, 6'b111000, 0, 0, 1'b0);
    run_q("bad_funct", 100);
  endtask

  task automatic test_reset_mid();
    gen(6'b100011, 6'h00, 0, 3, 1'b0);
    run_q("lw_pre_abort", 4);
    q.delete();
    #2 rst = 1'b1;
    #1 check_zero("reset_async_memrd");
    repeat (2) begin
      @(negedge clk);
      mem_ready_i = 1'b1;
      check_zero("reset_mid_held");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_srst_cycle");
    gen(6'b000010, 6'h00, 0, 0, 1'b0);
    run_q("jump_after_reset", 100);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                           6'b001101, 6'b000010, 6'b111111, 6'b000001};
    logic [5:0] fns[9] = '{6'b100000, 6'b100010, 6'b100101, 6'b100100, 6'b101010,
                           6'b100111, 6'b000010, 6'b111000, 6'b000000};
    for (int i = 0; i < 60; i++)
      gen(ops[$urandom_range(0, 8)], fns[$urandom_range(0, 8)],
          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    run_q("random", 10000);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_illegal_op();
    test_srl_bad_funct();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
